// File: rtl/encoder_pkg.sv
// -----------------------------------------------------------------------------
// encoder_pkg
//   Shared definitions for the sequential 4-to-2 scan encoder.
//
//   Contents:
//     state_t      - FSM encoding (ST_IDLE = 1'b0, ST_SCAN = 1'b1)
//     IN_W_DEF     - default request vector width
//     OUT_W_DEF    - default encoded index width (clog2 of IN_W_DEF)
//     popcount()   - set-bit count, only referenced when ENCODER_CNT_EN is
//                    defined (the optional cnt output)
// -----------------------------------------------------------------------------
package encoder_pkg;

  localparam int IN_W_DEF  = 4;
  localparam int OUT_W_DEF = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  // Number of set bits in a vector of up to 32 bits. Callers zero-extend
  // narrower vectors and truncate the result to their own count width.
  function automatic int popcount(input logic [31:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) begin
        n = n + 1;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/prio_enc.sv
// -----------------------------------------------------------------------------
// prio_enc
//   Purely combinational fixed-priority encoder: reports the index of the
//   highest set bit of vec (MSB wins) and whether any bit is set at all.
//
//   Parameters:
//     IN_W   - width of vec
//     OUT_W  - width of idx, expected to be clog2(IN_W)
//
//   Ports:
//     vec      in   IN_W   vector to encode
//     idx      out  OUT_W  index of the highest set bit (0 when vec == 0)
//     any_set  out  1      vec has at least one bit set
// -----------------------------------------------------------------------------
module prio_enc #(
  parameter int IN_W  = 4,
  parameter int OUT_W = 2
) (
  input  logic [IN_W-1:0]  vec,
  output logic [OUT_W-1:0] idx,
  output logic             any_set
);

  // Ascending scan: a later (higher) set bit overwrites an earlier one, so
  // the final value is the MSB-first winner.
  always_comb begin
    idx     = '0;
    any_set = 1'b0;
    for (int i = 0; i < IN_W; i++) begin
      if (vec[i]) begin
        idx     = OUT_W'(i);
        any_set = 1'b1;
      end
    end
  end

endmodule

// File: rtl/encoder_4_2_scan.sv
// -----------------------------------------------------------------------------
// encoder_4_2_scan
//   Sequential priority encoder. A multi-hot request vector is captured over
//   a valid/ready handshake, then the index of every set bit is emitted one
//   beat per output handshake, highest index first. A captured zero vector
//   produces no beats, only a one-cycle zero_err pulse.
//
//   Optional feature (macro ENCODER_CNT_EN): adds output cnt carrying the
//   number of set bits of the captured vector, held through the whole scan.
//
//   Parameters:
//     IN_W   - request vector width (default 4)
//     OUT_W  - index width, must equal clog2(IN_W) (default 2)
//
//   Ports:
//     clk        in   1        system clock, rising edge
//     rst        in   1        asynchronous active-high reset
//     in_valid   in   1        request vector a is valid
//     in_ready   out  1        block can accept a vector (IDLE)
//     a          in   IN_W     request vector, multi-hot
//     out_valid  out  1        b holds a valid index (SCAN)
//     out_ready  in   1        consumer accepts b
//     b          out  OUT_W    index of highest pending bit
//     out_last   out  1        b is the final pending index
//     zero_err   out  1        one-cycle pulse: a zero vector was accepted
//     cnt        out  OUT_W+1  popcount of captured vector (ENCODER_CNT_EN)
// -----------------------------------------------------------------------------
module encoder_4_2_scan
  import encoder_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  a,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] b,
  output logic             out_last,
`ifdef ENCODER_CNT_EN
  output logic             zero_err,
  output logic [OUT_W:0]   cnt
`else
  output logic             zero_err
`endif
);

  state_t            state_reg;
  logic [IN_W-1:0]   pend_reg;
  logic              zero_err_reg;
  logic [IN_W-1:0]   clear_mask;
  logic [OUT_W-1:0]  top_idx;
  logic              any_set;
  logic              single_bit;

  // Highest pending bit. b and out_last depend only on the registered pend
  // vector, so they are stable for as long as pend is (backpressure hold).
  prio_enc #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_prio_enc (
    .vec     (pend_reg),
    .idx     (top_idx),
    .any_set (any_set)
  );

  // One-hot mask selecting the bit currently presented on b.
  for (genvar gi = 0; gi < IN_W; gi++) begin : g_clear
    assign clear_mask[gi] = (top_idx == OUT_W'(gi));
  end

  // Exactly one bit set: nonzero and clearing the lowest set bit leaves 0.
  assign single_bit = any_set && ((pend_reg & (pend_reg - IN_W'(1))) == '0);

  assign in_ready  = (state_reg == ST_IDLE);
  assign out_valid = (state_reg == ST_SCAN);
  assign b         = top_idx;
  assign out_last  = (state_reg == ST_SCAN) && single_bit;
  assign zero_err  = zero_err_reg;

`ifdef ENCODER_CNT_EN
  logic [OUT_W:0] cnt_reg;
  assign cnt = cnt_reg;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      pend_reg     <= '0;
      zero_err_reg <= 1'b0;
`ifdef ENCODER_CNT_EN
      cnt_reg      <= '0;
`endif
    end else begin
      // zero_err is a pulse: it only survives the cycle after a zero capture.
      zero_err_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (in_valid) begin
            if (a != '0) begin
              pend_reg  <= a;
              state_reg <= ST_SCAN;
`ifdef ENCODER_CNT_EN
              cnt_reg   <= (OUT_W+1)'(popcount(32'(a)));
`endif
            end else begin
              zero_err_reg <= 1'b1;
`ifdef ENCODER_CNT_EN
              cnt_reg      <= '0;
`endif
            end
          end
        end
        ST_SCAN: begin
          // Input side is ignored here; a and in_valid have no effect.
          if (out_ready) begin
            // After the last beat pend drains to zero, which also returns
            // b to 0 while idle.
            pend_reg <= pend_reg & ~clear_mask;
            if (single_bit) begin
              state_reg <= ST_IDLE;
            end
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_encoder_4_2_scan.sv
// -----------------------------------------------------------------------------
// tb_encoder_4_2_scan
//   Self-checking bench for encoder_4_2_scan: a table of single vectors with
//   their expected index sequences, hand-written multi-cycle sequences
//   (backpressure, overlap, reset mid-scan), and a randomized run checked
//   against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_encoder_4_2_scan;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] a;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] b;
  logic       out_last;
  logic       zero_err;
`ifdef ENCODER_CNT_EN
  logic [2:0] cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  encoder_4_2_scan #(
    .IN_W  (4),
    .OUT_W (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .b         (b),
    .out_last  (out_last),
`ifdef ENCODER_CNT_EN
    .zero_err  (zero_err),
    .cnt       (cnt)
`else
    .zero_err  (zero_err)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one clock; outputs are then inspected 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cap(input logic [3:0] v);
    in_valid = 1'b1;
    a        = v;
    step();
    in_valid = 1'b0;
  endtask

  typedef struct {
    logic [3:0] a;
    int         n;     // number of beats expected
    logic [7:0] seq;   // beat k in seq[7-2k -: 2]
  } vec_t;

  vec_t vecs[7];

  // Reference model state for the randomized run.
  logic [1:0] exp_q[$];
  logic       m_zflag;
  int         m_cnt;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = 4'b0000;
    out_ready = 1'b0;

    vecs[0] = '{a: 4'b1111, n: 4, seq: 8'b11_10_01_00};
    vecs[1] = '{a: 4'b0001, n: 1, seq: 8'b00_00_00_00};
    vecs[2] = '{a: 4'b1000, n: 1, seq: 8'b11_00_00_00};
    vecs[3] = '{a: 4'b0110, n: 2, seq: 8'b10_01_00_00};
    vecs[4] = '{a: 4'b1010, n: 2, seq: 8'b11_01_00_00};
    vecs[5] = '{a: 4'b0000, n: 0, seq: 8'b00_00_00_00};
    vecs[6] = '{a: 4'b0111, n: 3, seq: 8'b10_01_00_00};

    // ---------------- reset state ----------------
    #1;
    step();
    step();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_b", b, 2'd0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_zero_err", zero_err, 1'b0);
`ifdef ENCODER_CNT_EN
    chk("rst_cnt", cnt, 3'd0);
`endif
    rst = 1'b0;
    step();

    // ---------------- table-driven vectors, out_ready held high ----------------
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      $display("vec %0d: a=%b beats=%0d", i, vecs[i].a, vecs[i].n);
      chk("tbl_in_ready_pre", in_ready, 1'b1);
      cap(vecs[i].a);
      if (vecs[i].n == 0) begin
        chk("tbl_zero_err_hi", zero_err, 1'b1);
        chk("tbl_zero_out_valid", out_valid, 1'b0);
        chk("tbl_zero_in_ready", in_ready, 1'b1);
        step();
        chk("tbl_zero_err_lo", zero_err, 1'b0);
        chk("tbl_zero_out_valid2", out_valid, 1'b0);
      end else begin
        for (int k = 0; k < vecs[i].n; k++) begin
          logic [7:0] s;
          s = vecs[i].seq;
          chk("tbl_out_valid", out_valid, 1'b1);
          chk("tbl_in_ready", in_ready, 1'b0);
          chk("tbl_b", b, s[7-2*k -: 2]);
          chk("tbl_out_last", out_last, (k == vecs[i].n - 1) ? 1'b1 : 1'b0);
          chk("tbl_zero_err", zero_err, 1'b0);
          step();
        end
        chk("tbl_done_out_valid", out_valid, 1'b0);
        chk("tbl_done_in_ready", in_ready, 1'b1);
      end
    end

    // ---------------- sparse vector with backpressure ----------------
    $display("seq: 0101 with 3 cycles backpressure");
    out_ready = 1'b0;
    cap(4'b0101);
    for (int k = 0; k < 3; k++) begin
      chk("bp_hold_valid", out_valid, 1'b1);
      chk("bp_hold_b", b, 2'd2);
      chk("bp_hold_last", out_last, 1'b0);
      step();
    end
    out_ready = 1'b1;
    chk("bp_b2", b, 2'd2);
    chk("bp_b2_last", out_last, 1'b0);
    step();
    chk("bp_b0", b, 2'd0);
    chk("bp_b0_last", out_last, 1'b1);
    chk("bp_b0_valid", out_valid, 1'b1);
    step();
    chk("bp_done_valid", out_valid, 1'b0);
    chk("bp_done_ready", in_ready, 1'b1);

    // ---------------- overlap: in_valid held during scan ----------------
    $display("seq: overlap 0011 then held 1000");
    in_valid = 1'b1;
    a        = 4'b0011;
    step();
    a = 4'b1000;
    chk("ov_b1", b, 2'd1);
    chk("ov_b1_last", out_last, 1'b0);
    chk("ov_in_ready0", in_ready, 1'b0);
    step();
    chk("ov_b0", b, 2'd0);
    chk("ov_b0_last", out_last, 1'b1);
    step();
    chk("ov_idle_valid", out_valid, 1'b0);
    chk("ov_idle_ready", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    chk("ov_new_valid", out_valid, 1'b1);
    chk("ov_new_b", b, 2'd3);
    chk("ov_new_last", out_last, 1'b1);
    step();
    chk("ov_done_valid", out_valid, 1'b0);

    // ---------------- reset in the middle of a scan ----------------
    $display("seq: reset mid-scan of 1110");
    cap(4'b1110);
    chk("mr_b3", b, 2'd3);
    step();
    chk("mr_b2", b, 2'd2);
    chk("mr_valid_pre", out_valid, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("mr_async_valid", out_valid, 1'b0);
    chk("mr_async_ready", in_ready, 1'b1);
    chk("mr_async_b", b, 2'd0);
    step();
    step();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      chk("mr_no_stale_valid", out_valid, 1'b0);
      chk("mr_no_stale_zero", zero_err, 1'b0);
      step();
    end

`ifdef ENCODER_CNT_EN
    // ---------------- optional count output ----------------
    $display("seq: cnt for 1011");
    cap(4'b1011);
    for (int k = 0; k < 3; k++) begin
      chk("cnt_hold", cnt, 3'd3);
      step();
    end
    cap(4'b0000);
    chk("cnt_zero", cnt, 3'd0);
    step();
`endif

    // ---------------- randomized run against queue model ----------------
    $display("random: 400 cycles");
    exp_q.delete();
    m_zflag = 1'b0;
    m_cnt   = 0;
    for (int c = 0; c < 400; c++) begin
      logic zf_next;
      chk("rnd_out_valid", out_valid, (exp_q.size() != 0) ? 1'b1 : 1'b0);
      chk("rnd_in_ready", in_ready, (exp_q.size() == 0) ? 1'b1 : 1'b0);
      chk("rnd_zero_err", zero_err, m_zflag);
      if (exp_q.size() != 0) begin
        chk("rnd_b", b, exp_q[0]);
        chk("rnd_out_last", out_last, (exp_q.size() == 1) ? 1'b1 : 1'b0);
      end else begin
        chk("rnd_idle_b", b, 2'd0);
      end
`ifdef ENCODER_CNT_EN
      chk("rnd_cnt", cnt, m_cnt);
`endif
      in_valid  = ($urandom_range(0, 1) == 1);
      a         = ($urandom_range(0, 7) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);

      // Model of the edge about to happen.
      zf_next = 1'b0;
      if (exp_q.size() == 0) begin
        if (in_valid) begin
          if (a == 4'b0000) begin
            zf_next = 1'b1;
            m_cnt   = 0;
          end else begin
            m_cnt = 0;
            for (int i = 3; i >= 0; i--) begin
              if (a[i]) begin
                exp_q.push_back(2'(i));
                m_cnt++;
              end
            end
          end
        end
      end else if (out_ready) begin
        void'(exp_q.pop_front());
      end
      m_zflag = zf_next;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/encoder_4_2_scan.md
Name: encoder_4_2_scan

Overview:
- Sequential priority encoder, the inverse of the team's 2-to-4 decoder.
- Accepts a multi-hot request vector `a` over a valid/ready handshake and latches it.
- Emits the binary index `b` of every set bit, one per output handshake, highest index first.
- Sits between the request sources and any consumer expecting encoded indices; zero vectors are flagged and dropped.

Parameters:
- IN_W, 4, width of request vector a
- OUT_W, 2, width of encoded index b; must equal clog2(IN_W)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  request vector a is valid
- in_ready  out  1  block can accept a vector
- a  in  IN_W  request vector, multi-hot
- out_valid  out  1  b holds a valid index
- out_ready  in  1  consumer accepts b
- b  out  OUT_W  encoded index of highest pending bit
- out_last  out  1  b is the final pending index of the captured vector
- zero_err  out  1  one-cycle pulse: a zero vector was accepted

Behaviour:
- One clock (clk). Reset rst is asynchronous and active-high.
- Reset values: state=IDLE, pend=0, out_valid=0, b=0, out_last=0, zero_err=0, in_ready=1.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - SCAN: in_ready=0, out_valid=1.
- IDLE transitions:
  - Capture occurs on in_valid&&in_ready.
  - a!=0: pend<=a, go to SCAN.
  - a==0: stay in IDLE, zero_err=1 for exactly the next cycle.
- Latency: capture at edge k gives out_valid=1 from the cycle after edge k, i.e. 1 clock.
- SCAN outputs:
  - b = index of the highest set bit of pend (MSB-first fixed priority).
  - out_last = 1 when pend has exactly one bit set.
  - b and out_last are derived from registered pend only, never directly from a.
- SCAN, on out_ready:
  - Clear bit b in pend.
  - If that was the last bit (out_last=1), return to IDLE at the same edge.
  - Otherwise stay in SCAN.
- Hold rule: while out_valid&&!out_ready, b, out_last and pend are stable.
- Throughput: one index per cycle when out_ready is held high. A vector with n set bits occupies SCAN for n cycles.
- in_ready deasserts during SCAN; no new capture is possible until return to IDLE. The first capture can occur in the cycle after the last out handshake.
- in_valid during SCAN is ignored; the source must hold it per the valid/ready rules.
- Changes of a while in SCAN have no effect.
- Boundaries:
  - All ones (a=4'b1111): b sequence 3,2,1,0, with out_last only on 0.
  - Single bit: one beat, out_last=1.
  - Zero vector: no out_valid, zero_err pulse only.
- Reset mid-SCAN: immediate return to reset values. Pending bits are discarded and no further beats are emitted.

Optional Feature:
- Macro: ENCODER_CNT_EN.
- Defined:
  - Extra output cnt, width OUT_W+1.
  - On capture, cnt = popcount(a); held constant through SCAN.
  - Reset value 0. Cleared to 0 on a zero-vector capture.
- Undefined: the cnt port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package encoder_pkg:
  - State encoding constants ST_IDLE=1'b0, ST_SCAN=1'b1.
  - Default IN_W=4 and OUT_W=2 constants.
  - Popcount function, used only under ENCODER_CNT_EN.
- Sub-module prio_enc: purely combinational highest-set-bit encoder, IN_W to OUT_W plus an any_set flag. Instantiated once on pend.
- The FSM, pend register and handshake logic stay in encoder_4_2_scan.

Test Plan:
- Reset: rst=1 for 2 cycles mid-stream.
  - Required: out_valid=0, in_ready=1, b=0, zero_err=0.
  - After release, no stale beats appear.
- Full vector: a=4'b1111 captured, out_ready=1.
  - Required: b=3,2,1,0 on consecutive cycles, out_last=1 only with b=0.
  - in_ready returns to 1 the cycle after.
- Sparse with backpressure: a=4'b0101, out_ready low for 3 cycles.
  - Required: b=2 held stable, then b=2, then b=0 with out_last=1.
- Zero vector: a=4'b0000 accepted.
  - Required: zero_err=1 for exactly 1 cycle, out_valid stays 0, in_ready stays 1.
- Overlap: in_valid held with a=4'b1000 during SCAN of 4'b0011.
  - Required: new vector captured only after b=0 handshake.
  - Next beat is b=3 with out_last=1.
- Reset mid-SCAN of 4'b1110 after the first beat: out_valid drops asynchronously, and b=1 is never emitted.
- ENCODER_CNT_EN only: a=4'b1011 gives cnt=3 through all three beats.
